// File: rtl/param_simple_processor.sv
// param_simple_processor: multi-cycle 8-register processor with ALU flags and conditional move.
module param_simple_processor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [WIDTH-1:0] din,
    output logic             done,
    output logic [WIDTH-1:0] buswires,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic             flag_z,
    output logic             flag_c
);
    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
    localparam logic [2:0] MV = 3'd0, MVI = 3'd1, ADD = 3'd2, SUB = 3'd3;
    localparam logic [2:0] AND_OP = 3'd4, OR_OP = 3'd5, XOR_OP = 3'd6, MVNZ = 3'd7;
    state_t           state;
    logic [WIDTH-1:0] regs [8];
    logic [WIDTH-1:0] a, g, result;
    logic [8:0]       ir;
    logic [WIDTH:0]   sum;
    logic [2:0]       op, rx, ry;
    logic             mv_class, carry;
    assign op       = ir[8:6];
    assign rx       = ir[5:3];
    assign ry       = ir[2:0];
    assign mv_class = op == MV || op == MVI || op == MVNZ;
    assign r0       = regs[0];
    assign r1       = regs[1];
    assign done     = (state == T1 && mv_class) || state == T3;
    always_comb begin
        buswires = state == T1 ? (op == MVI ? din : mv_class ? regs[ry] : regs[rx]) :
                   state == T2 ? regs[ry] :
                   state == T3 ? g : '0;
    end
    // subtraction reuses the adder as A + ~B + 1 so the carry out means A >= B
    always_comb begin
        sum    = {1'b0, a} + {1'b0, op == SUB ? ~buswires : buswires} + {{WIDTH{1'b0}}, op == SUB};
        result = op == AND_OP ? a & buswires :
                 op == OR_OP  ? a | buswires :
                 op == XOR_OP ? a ^ buswires : sum[WIDTH-1:0];
        carry  = (op == ADD || op == SUB) && sum[WIDTH];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= T0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            a      <= '0;
            g      <= '0;
            ir     <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            case (state)
                T0: if (run) begin
                    ir    <= din[8:0];
                    state <= T1;
                end
                T1: if (mv_class) begin
                    if (op != MVNZ || !flag_z) regs[rx] <= buswires;
                    state <= T0;
                end else begin
                    a     <= buswires;
                    state <= T2;
                end
                T2: begin
                    g      <= result;
                    flag_z <= result == '0;
                    flag_c <= carry;
                    state  <= T3;
                end
                T3: begin
                    regs[rx] <= g;
                    state    <= T0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_param_simple_processor.sv
// tb_param_simple_processor: directed tests for param_simple_processor with hand-computed results.
module tb_param_simple_processor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [15:0] din = '0;
    logic        done, flag_z, flag_c;
    logic [15:0] buswires, r0, r1;
    int          tests = 0;
    int          fails = 0;

    param_simple_processor #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .din(din), .done(done),
        .buswires(buswires), .r0(r0), .r1(r1), .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one instruction and records done in T1 (bit 0), T2 and T3; ends back in T0.
    task automatic issue(input logic [15:0] ins, input logic [15:0] imm, input bit alu,
                         output logic [2:0] dtr);
        dtr = '0;
        run = 1'b1;
        din = ins;
        tick();
        run = 1'b0;
        din = imm;
        dtr[0] = done;
        if (alu) begin
            tick();
            dtr[1] = done;
            tick();
            dtr[2] = done;
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tests++; if (r0 !== 16'h0) begin fails++; $display("FAIL reset_r0 got %h want 0000", r0); end
        tests++; if (r1 !== 16'h0) begin fails++; $display("FAIL reset_r1 got %h want 0000", r1); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (buswires !== 16'h0) begin fails++; $display("FAIL reset_bus got %h want 0000", buswires); end
        tests++; if ({flag_z, flag_c} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {flag_z, flag_c}); end
        for (int i = 0; i < 5; i++) begin
            din = 16'h0040;
            tick();
            tests++; if ({done, buswires, r0} !== 33'h0) begin fails++; $display("FAIL idle_%0d got done=%b bus=%h r0=%h want 0", i, done, buswires, r0); end
        end
    endtask

    task automatic test_mvi();
        logic [2:0] d;
        issue(16'h0040, 16'h0005, 1'b0, d);
        tests++; if (d !== 3'b001) begin fails++; $display("FAIL mvi_done got %b want 001", d); end
        tests++; if (r0 !== 16'h0005) begin fails++; $display("FAIL mvi_r0 got %h want 0005", r0); end
        issue(16'h0048, 16'h0007, 1'b0, d);
        tests++; if (r1 !== 16'h0007) begin fails++; $display("FAIL mvi_r1 got %h want 0007", r1); end
        tests++; if ({flag_z, flag_c} !== 2'b00) begin fails++; $display("FAIL mvi_flags got %b want 00", {flag_z, flag_c}); end
    endtask

    task automatic test_add_sub();
        logic [2:0] d;
        issue(16'h0081, 16'h0000, 1'b1, d);
        tests++; if (d !== 3'b100) begin fails++; $display("FAIL add_done got %b want 100", d); end
        tests++; if (r0 !== 16'd12) begin fails++; $display("FAIL add_r0 got %h want 000c", r0); end
        tests++; if ({flag_z, flag_c} !== 2'b00) begin fails++; $display("FAIL add_flags got %b want 00", {flag_z, flag_c}); end
        issue(16'h00C8, 16'h0000, 1'b1, d);
        tests++; if (r1 !== 16'hFFFB) begin fails++; $display("FAIL sub_r1 got %h want fffb", r1); end
        tests++; if ({flag_z, flag_c} !== 2'b00) begin fails++; $display("FAIL sub_flags got %b want 00", {flag_z, flag_c}); end
    endtask

    task automatic test_wrap_mvnz();
        logic [2:0] d;
        issue(16'h0040, 16'hFFFF, 1'b0, d);
        issue(16'h0048, 16'h0001, 1'b0, d);
        issue(16'h0081, 16'h0000, 1'b1, d);
        tests++; if (r0 !== 16'h0000) begin fails++; $display("FAIL wrap_r0 got %h want 0000", r0); end
        tests++; if ({flag_z, flag_c} !== 2'b11) begin fails++; $display("FAIL wrap_flags got %b want 11", {flag_z, flag_c}); end
        issue(16'h01C8, 16'h0000, 1'b0, d);
        tests++; if (d !== 3'b001) begin fails++; $display("FAIL mvnz_done got %b want 001", d); end
        tests++; if (r1 !== 16'h0001) begin fails++; $display("FAIL mvnz_skip_r1 got %h want 0001", r1); end
        tests++; if ({flag_z, flag_c} !== 2'b11) begin fails++; $display("FAIL mvnz_flags got %b want 11", {flag_z, flag_c}); end
        issue(16'h0181, 16'h0000, 1'b1, d);
        tests++; if (r0 !== 16'h0001) begin fails++; $display("FAIL xor_r0 got %h want 0001", r0); end
        tests++; if ({flag_z, flag_c} !== 2'b00) begin fails++; $display("FAIL xor_flags got %b want 00", {flag_z, flag_c}); end
        issue(16'h01C8, 16'h0000, 1'b0, d);
        tests++; if (r1 !== 16'h0001) begin fails++; $display("FAIL mvnz_take_r1 got %h want 0001", r1); end
        issue(16'h0040, 16'h0055, 1'b0, d);
        issue(16'h01C8, 16'h0000, 1'b0, d);
        tests++; if (r1 !== 16'h0055) begin fails++; $display("FAIL mvnz_take2_r1 got %h want 0055", r1); end
    endtask

    task automatic test_logic_mv();
        logic [2:0] d;
        issue(16'h0040, 16'h00F0, 1'b0, d);
        issue(16'h0048, 16'h0F0F, 1'b0, d);
        issue(16'h0101, 16'h0000, 1'b1, d);
        tests++; if (r0 !== 16'h0000) begin fails++; $display("FAIL and_r0 got %h want 0000", r0); end
        tests++; if ({flag_z, flag_c} !== 2'b10) begin fails++; $display("FAIL and_flags got %b want 10", {flag_z, flag_c}); end
        issue(16'h0040, 16'h00F0, 1'b0, d);
        issue(16'h0141, 16'h0000, 1'b1, d);
        tests++; if (r0 !== 16'h0FFF) begin fails++; $display("FAIL or_r0 got %h want 0fff", r0); end
        tests++; if ({flag_z, flag_c} !== 2'b00) begin fails++; $display("FAIL or_flags got %b want 00", {flag_z, flag_c}); end
        issue(16'h0008, 16'h0000, 1'b0, d);
        tests++; if (r1 !== 16'h0FFF) begin fails++; $display("FAIL mv_r1 got %h want 0fff", r1); end
        issue(16'h0089, 16'h0000, 1'b1, d);
        tests++; if (r1 !== 16'h1FFE) begin fails++; $display("FAIL double_r1 got %h want 1ffe", r1); end
        issue(16'h00C0, 16'h0000, 1'b1, d);
        tests++; if ({r0, flag_z, flag_c} !== 18'h00003) begin fails++; $display("FAIL subself got r0=%h zc=%b want 0000 11", r0, {flag_z, flag_c}); end
    endtask

    task automatic test_back_to_back();
        run = 1'b1;
        din = 16'h0040;
        tick();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done1 got %b want 1", done); end
        din = 16'h0021;
        tick();
        tests++; if ({done, buswires} !== 17'h0) begin fails++; $display("FAIL b2b_gap got done=%b bus=%h want 0", done, buswires); end
        din = 16'h0048;
        tick();
        tests++; if ({done, buswires} !== 17'h10022 - 17'h0022 + {1'b0, din}) begin fails++; $display("FAIL b2b_t1 got done=%b bus=%h", done, buswires); end
        run = 1'b0;
        din = 16'h0022;
        tick();
        tests++; if ({r0, r1} !== 32'h0021_0022) begin fails++; $display("FAIL b2b_regs got %h %h want 0021 0022", r0, r1); end
    endtask

    task automatic test_busy_reset();
        logic [2:0] d;
        issue(16'h0040, 16'h0003, 1'b0, d);
        issue(16'h0048, 16'h0004, 1'b0, d);
        run = 1'b1;
        din = 16'h0081;
        tick();
        run = 1'b0;
        tick();
        run = 1'b1;
        din = 16'h0040;
        tick();
        run = 1'b0;
        tests++; if ({done, buswires} !== 17'h10007) begin fails++; $display("FAIL busy_t3 got done=%b bus=%h want 1 0007", done, buswires); end
        tick();
        tests++; if (r0 !== 16'h0007) begin fails++; $display("FAIL busy_r0 got %h want 0007", r0); end
        tick();
        tests++; if ({done, buswires, r0} !== 33'h0_0000_0007) begin fails++; $display("FAIL busy_ignored got done=%b bus=%h r0=%h", done, buswires, r0); end
        issue(16'h00C9, 16'h0000, 1'b1, d);
        issue(16'h0040, 16'h0003, 1'b0, d);
        run = 1'b1;
        din = 16'h0081;
        tick();
        run = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests++; if ({r0, r1} !== 32'h0) begin fails++; $display("FAIL abort_regs got %h %h want 0", r0, r1); end
        tests++; if ({done, buswires, flag_z, flag_c} !== 19'h0) begin fails++; $display("FAIL abort_state got done=%b bus=%h zc=%b", done, buswires, {flag_z, flag_c}); end
        tick();
        tests++; if ({done, r0} !== 17'h0) begin fails++; $display("FAIL abort_idle got done=%b r0=%h want 0", done, r0); end
        issue(16'h0048, 16'h0009, 1'b0, d);
        tests++; if ({d, r1} !== {3'b001, 16'h0009}) begin fails++; $display("FAIL post_reset_mvi got d=%b r1=%h want 001 0009", d, r1); end
    endtask

    initial begin
        test_reset();
        test_mvi();
        test_add_sub();
        test_wrap_mvnz();
        test_logic_mv();
        test_back_to_back();
        test_busy_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
